// File: rtl/awe_dsp_operand_sequencer.sv
// awe_dsp_operand_sequencer
// Feeds awe_dsp_input_mux. Accepts 4-operand bundles over valid/ready, holds the
// active bundle on datain_0..3 and steps 'mode' through operands 0..count, one per
// cycle. A one-deep shadow bank lets consecutive bundles issue without a bubble.
// Optional build macro: AWE_SEQ_PERF_CNT_EN adds perf_ops / perf_bundles counters.
module awe_dsp_operand_sequencer #(
    parameter int unsigned C_DATA_WIDTH = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [C_DATA_WIDTH-1:0] in_data_0,
    input  logic [C_DATA_WIDTH-1:0] in_data_1,
    input  logic [C_DATA_WIDTH-1:0] in_data_2,
    input  logic [C_DATA_WIDTH-1:0] in_data_3,
    input  logic [1:0]              in_count,
    input  logic                    dsp_stall,
    output logic [1:0]              mode,
    output logic [C_DATA_WIDTH-1:0] datain_0,
    output logic [C_DATA_WIDTH-1:0] datain_1,
    output logic [C_DATA_WIDTH-1:0] datain_2,
    output logic [C_DATA_WIDTH-1:0] datain_3,
    output logic                    op_valid,
    output logic                    op_first,
    output logic                    op_last
`ifdef AWE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]             perf_ops,
    output logic [31:0]             perf_bundles
`endif
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state, state_next;
    logic [1:0]              mode_next;
    logic [1:0]              act_count;
    logic [1:0]              sh_count;
    logic [C_DATA_WIDTH-1:0] sh_data_0, sh_data_1, sh_data_2, sh_data_3;
    logic                    sh_full;
    logic                    accept;
    logic                    load_act_in, load_act_sh, load_sh, clr_sh;

    assign in_ready = ~sh_full & ~rst & ~flush;
    assign accept   = in_valid & in_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state, bank-load controls and operand-valid outputs
    always_comb begin
        state_next  = state;
        mode_next   = mode;
        load_act_in = 1'b0;
        load_act_sh = 1'b0;
        load_sh     = 1'b0;
        clr_sh      = 1'b0;
        op_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    mode_next = '0;
                    clr_sh    = 1'b1;
                end else if (accept) begin
                    load_act_in = 1'b1;
                    mode_next   = '0;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                op_valid = ~dsp_stall;
                if (flush) begin
                    state_next = IDLE;
                    mode_next  = '0;
                    clr_sh     = 1'b1;
                end else if (~dsp_stall && mode == act_count) begin
                    // Completion: the shadow drains first; a fresh accept is only
                    // possible when the shadow is empty since in_ready masks it.
                    mode_next = '0;
                    if (sh_full) begin
                        load_act_sh = 1'b1;
                        clr_sh      = 1'b1;
                    end else if (accept) begin
                        load_act_in = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (~dsp_stall) mode_next = mode + 2'd1;
                    if (accept)     load_sh   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        op_first = op_valid & (mode == 2'd0);
        op_last  = op_valid & (mode == act_count);
    end

    // Mode select, active bank and shadow bank registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode      <= '0;
            act_count <= '0;
            datain_0  <= '0;
            datain_1  <= '0;
            datain_2  <= '0;
            datain_3  <= '0;
            sh_count  <= '0;
            sh_data_0 <= '0;
            sh_data_1 <= '0;
            sh_data_2 <= '0;
            sh_data_3 <= '0;
            sh_full   <= 1'b0;
        end else begin
            mode <= mode_next;
            if (load_act_in) begin
                datain_0  <= in_data_0;
                datain_1  <= in_data_1;
                datain_2  <= in_data_2;
                datain_3  <= in_data_3;
                act_count <= in_count;
            end else if (load_act_sh) begin
                datain_0  <= sh_data_0;
                datain_1  <= sh_data_1;
                datain_2  <= sh_data_2;
                datain_3  <= sh_data_3;
                act_count <= sh_count;
            end
            if (load_sh) begin
                sh_data_0 <= in_data_0;
                sh_data_1 <= in_data_1;
                sh_data_2 <= in_data_2;
                sh_data_3 <= in_data_3;
                sh_count  <= in_count;
                sh_full   <= 1'b1;
            end else if (clr_sh) begin
                sh_full <= 1'b0;
            end
        end
    end

`ifdef AWE_SEQ_PERF_CNT_EN
    // Issued-operand and completed-bundle counters; free-running, flush does not clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops     <= '0;
            perf_bundles <= '0;
        end else begin
            if (op_valid) perf_ops     <= perf_ops + 32'd1;
            if (op_last)  perf_bundles <= perf_bundles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_awe_dsp_operand_sequencer.sv
// Scoreboard bench for awe_dsp_operand_sequencer: directed bundles push the expected
// operand stream; a negedge monitor pops and compares on every op_valid.
module tb_awe_dsp_operand_sequencer;

    localparam int W = 18;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, dsp_stall;
    logic         in_ready, op_valid, op_first, op_last;
    logic [1:0]   in_count, mode;
    logic [W-1:0] in_data_0, in_data_1, in_data_2, in_data_3;
    logic [W-1:0] datain_0, datain_1, datain_2, datain_3;
`ifdef AWE_SEQ_PERF_CNT_EN
    logic [31:0]  perf_ops, perf_bundles;
`endif

    int           tests = 0;
    int           fails = 0;
    logic [75:0]  exp_q[$];
    logic [75:0]  got;

    awe_dsp_operand_sequencer #(.C_DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data_0(in_data_0), .in_data_1(in_data_1),
        .in_data_2(in_data_2), .in_data_3(in_data_3),
        .in_count(in_count), .dsp_stall(dsp_stall), .mode(mode),
        .datain_0(datain_0), .datain_1(datain_1),
        .datain_2(datain_2), .datain_3(datain_3),
        .op_valid(op_valid), .op_first(op_first), .op_last(op_last)
`ifdef AWE_SEQ_PERF_CNT_EN
        , .perf_ops(perf_ops), .perf_bundles(perf_bundles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] bun(input logic [W-1:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    task automatic offer(input logic [71:0] d, input logic [1:0] cnt);
        in_valid  = 1'b1;
        in_data_0 = d[71:54];
        in_data_1 = d[53:36];
        in_data_2 = d[35:18];
        in_data_3 = d[17:0];
        in_count  = cnt;
    endtask

    // Push the first n operands of a bundle: {mode, data, first, last}
    task automatic expect_ops(input logic [71:0] d, input logic [1:0] cnt, input int unsigned n);
        logic [1:0] m;
        for (int unsigned i = 0; i < n; i++) begin
            m = 2'(i);
            exp_q.push_back({m, d, m == 2'd0, m == cnt});
        end
    endtask

    // Monitor: every presented operand must match the head of the scoreboard
    always @(negedge clk) begin
        if (op_valid === 1'b1) begin
            got = {mode, datain_0, datain_1, datain_2, datain_3, op_first, op_last};
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_op: got %h with empty scoreboard", got);
            end else begin
                check("op_stream", got, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [71:0] b1, ba, bb, bc, bd, bs, bx, by, br;
        b1 = bun(18'h11, 18'h22, 18'h33, 18'h44);
        ba = bun(18'h01, 18'h02, 18'h03, 18'h04);
        bb = bun(18'h05, 18'h06, 18'h07, 18'h08);
        bc = bun(18'h09, 18'h0a, 18'h0b, 18'h0c);
        bd = bun(18'h0d, 18'h0e, 18'h0f, 18'h10);
        bs = bun(18'h21, 18'h22, 18'h23, 18'h24);
        bx = bun(18'h31, 18'h32, 18'h33, 18'h34);
        by = bun(18'h41, 18'h42, 18'h43, 18'h44);
        br = bun(18'h51, 18'h52, 18'h53, 18'h54);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; dsp_stall = 1'b0; in_count = '0;
        in_data_0 = '0; in_data_1 = '0; in_data_2 = '0; in_data_3 = '0;
        step(); step();
        check("rst_outputs", {mode, op_valid, op_first, op_last, in_ready}, {2'd0, 4'b0000});
        check("rst_datain", {datain_0, datain_1, datain_2, datain_3}, '0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1'b1);

        // Single bundle, count=3; in_count changed mid-bundle must be ignored
        offer(b1, 2'd3);
        step();
        in_valid = 1'b0; in_count = 2'd0;
        expect_ops(b1, 2'd3, 4);
        check("t1_first_latency", {op_valid, op_first, mode}, {2'b11, 2'd0});
        step(); step(); step();
        check("t1_last", {op_valid, op_last, mode}, {2'b11, 2'd3});
        step();
        check("t1_idle", {op_valid, mode, in_ready}, {1'b0, 2'd0, 1'b1});

        // Back-to-back via shadow: A(count=1) then B(count=2)
        offer(ba, 2'd1);
        step();
        expect_ops(ba, 2'd1, 2);
        expect_ops(bb, 2'd2, 3);
        check("t2_a0", {op_valid, mode}, {1'b1, 2'd0});
        offer(bb, 2'd2);
        step();
        in_valid = 1'b0;
        check("t2_a1", {op_valid, mode}, {1'b1, 2'd1});
        check("t2_shadow_full_ready", in_ready, 1'b0);
        step();
        check("t2_b0", {op_valid, mode, in_ready}, {1'b1, 2'd0, 1'b1});
        step();
        check("t2_b1", {op_valid, mode}, {1'b1, 2'd1});
        step();
        check("t2_b2", {op_valid, mode}, {1'b1, 2'd2});
        step();
        check("t2_idle", op_valid, 1'b0);

        // Zero-bubble accept at completion with an empty shadow: C(count=0), D(count=1)
        offer(bc, 2'd0);
        step();
        expect_ops(bc, 2'd0, 1);
        expect_ops(bd, 2'd1, 2);
        offer(bd, 2'd1);
        step();
        in_valid = 1'b0;
        check("t2z_d0", {op_valid, mode, datain_0}, {1'b1, 2'd0, 18'h0d});
        step();
        check("t2z_d1", {op_valid, mode}, {1'b1, 2'd1});
        step();
        check("t2z_idle", op_valid, 1'b0);

        // Stall for 3 cycles at mode=1
        offer(bs, 2'd3);
        step();
        in_valid = 1'b0;
        expect_ops(bs, 2'd3, 4);
        step();
        dsp_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_stalled", {op_valid, op_first, op_last, mode}, {3'b000, 2'd1});
            step();
        end
        dsp_stall = 1'b0;
        #1;
        check("t3_resume", {op_valid, mode}, {1'b1, 2'd1});
        step();
        check("t3_m2", {op_valid, mode}, {1'b1, 2'd2});
        step();
        check("t3_m3", {op_valid, op_last, mode}, {2'b11, 2'd3});
        step();

        // Flush with active mid-bundle and shadow full; Y must never issue
        offer(bx, 2'd3);
        step();
        expect_ops(bx, 2'd3, 2);
        offer(by, 2'd2);
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        check("t4_flush_cycle_ready", in_ready, 1'b0);
        step();
        flush = 1'b0;
        #1;
        check("t4_after_flush", {op_valid, mode, in_ready}, {1'b0, 2'd0, 1'b1});
        check("t4_datain_held", datain_0, 18'h31);
        step(); step(); step();
        check("t4_still_idle", op_valid, 1'b0);

        // Async reset mid-issue at mode=2
        offer(br, 2'd3);
        step();
        in_valid = 1'b0;
        expect_ops(br, 2'd3, 2);
        step(); step();
        check("t5_pre_rst", mode, 2'd2);
        rst = 1'b1;
        #1;
        check("t5_rst_async", {mode, op_valid, in_ready}, {2'd0, 2'b00});
        check("t5_rst_datain", {datain_0, datain_1, datain_2, datain_3}, '0);
        step();
        rst = 1'b0;
        #1;
        check("t5_rel_ready", in_ready, 1'b1);

`ifdef AWE_SEQ_PERF_CNT_EN
        check("perf_rst", {perf_ops, perf_bundles}, '0);
        offer(b1, 2'd3); step(); in_valid = 1'b0; expect_ops(b1, 2'd3, 4);
        step(); step(); step(); step();
        offer(bs, 2'd3); step(); in_valid = 1'b0; expect_ops(bs, 2'd3, 4);
        step(); step(); step(); step();
        offer(bc, 2'd0); step(); in_valid = 1'b0; expect_ops(bc, 2'd0, 1);
        step();
        check("perf_ops_9", perf_ops, 32'd9);
        check("perf_bundles_3", perf_bundles, 32'd3);
        force dut.perf_ops = 32'hFFFF_FFFF;
        #1;
        release dut.perf_ops;
        offer(bd, 2'd0); step(); in_valid = 1'b0; expect_ops(bd, 2'd0, 1);
        step();
        check("perf_ops_wrap", perf_ops, 32'd0);
        check("perf_bundles_4", perf_bundles, 32'd4);
`endif

        step(); step();
        check("scoreboard_drained", 76'(exp_q.size()), 76'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
